// File: rtl/pio_out_multi.sv
// Multi-bit parallel output port with DATA/SET/CLR registers and optional timed pulse inversion.
// Pulse feature (mask, counter, FSM, PLEN/PCNT) is compiled in when PIO_OUT_MULTI_PULSE_EN is defined.
module pio_out_multi #(
  parameter int unsigned          WIDTH        = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE  = '0,
  parameter int unsigned          PULSE_CW     = 16,
  parameter logic [PULSE_CW-1:0]  DEFAULT_PLEN = PULSE_CW'(16)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_SET   = 3'd1;
  localparam logic [2:0] ADDR_CLR   = 3'd2;
  localparam logic [2:0] ADDR_PULSE = 3'd3;
  localparam logic [2:0] ADDR_PLEN  = 3'd4;
  localparam logic [2:0] ADDR_PCNT  = 3'd5;

  logic             wr_en_c;
  logic [WIDTH-1:0] wr_val_c;
  logic [WIDTH-1:0] data_q, data_d;
  logic             unused_c;

  assign wr_en_c  = chipselect & ~write_n;
  assign wr_val_c = writedata[WIDTH-1:0];
  assign unused_c = ^writedata;

  // DATA register with direct, set and clear write paths
  always_comb begin
    data_d = data_q;
    if (wr_en_c) begin
      case (address)
        ADDR_DATA: data_d = wr_val_c;
        ADDR_SET:  data_d = data_q | wr_val_c;
        ADDR_CLR:  data_d = data_q & ~wr_val_c;
        default:   data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_q <= RESET_VALUE;
    else          data_q <= data_d;
  end

`ifdef PIO_OUT_MULTI_PULSE_EN
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [PULSE_CW-1:0] cnt_q, cnt_d;
  logic [PULSE_CW-1:0] plen_q, plen_d;
  logic [WIDTH-1:0]    mask_q, mask_d;
  logic                pulse_go_c;

  assign pulse_go_c = wr_en_c && (address == ADDR_PULSE) && (|wr_val_c) && (|plen_q);

  // A valid PULSE write always reloads, even on the cycle the count expires
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    plen_d  = plen_q;
    if (wr_en_c && (address == ADDR_PLEN)) plen_d = writedata[PULSE_CW-1:0];
    case (state_q)
      IDLE: begin
        if (pulse_go_c) begin
          mask_d  = wr_val_c;
          cnt_d   = plen_q;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (pulse_go_c) begin
          mask_d = mask_q | wr_val_c;
          cnt_d  = plen_q;
        end else if (cnt_q == PULSE_CW'(1)) begin
          mask_d  = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - PULSE_CW'(1);
        end
      end
      default: begin
        mask_d  = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      plen_q  <= DEFAULT_PLEN;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      plen_q  <= plen_d;
    end
  end

  assign out_port = data_q ^ mask_q;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:  readdata = 32'(data_q);
      ADDR_PULSE: readdata = 32'(mask_q);
      ADDR_PLEN:  readdata = 32'(plen_q);
      ADDR_PCNT:  readdata = 32'(cnt_q);
      default:    readdata = '0;
    endcase
  end
`else
  assign out_port = data_q;

  always_comb begin
    readdata = '0;
    if (address == ADDR_DATA) readdata = 32'(data_q);
  end
`endif

endmodule

// File: doc/pio_out_multi.md
PIO_OUT_MULTI -- requirements
Module: pio_out_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the number of output bits (legal range 1..32).
REQ-002 SHALL have parameter RESET_VALUE, default 0, the reset value of the DATA register (WIDTH bits).
REQ-003 SHALL have parameter PULSE_CW, default 16, the bit width of the pulse-length register and counter (legal range 1..32).
REQ-004 SHALL have parameter DEFAULT_PLEN, default 16, the reset value of PLEN.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port address, input, 3 bits, register select.
REQ-008 SHALL have port chipselect, input, 1 bit, slave select.
REQ-009 SHALL have port write_n, input, 1 bit, active-low write strobe.
REQ-010 SHALL have port writedata, input, 32 bits, write data.
REQ-011 SHALL have port readdata, output, 32 bits, combinational read data with zero wait states.
REQ-012 SHALL have port out_port, output, WIDTH bits, the driven output pins.

Function
REQ-013 SHALL treat a write as chipselect=1 and write_n=0 in a clock cycle; only writedata[WIDTH-1:0] is used, except for PLEN.
REQ-014 SHALL implement this address map:
- 0 DATA: R/W.
- 1 SET: W1S into DATA; reads 0.
- 2 CLR: W1C from DATA; reads 0.
- 3 PULSE: write = pulse mask; read = active mask.
- 4 PLEN: R/W, PULSE_CW bits.
- 5 PCNT: read-only remaining count.
- 6 and 7: read 0; writes ignored.
REQ-015 SHALL zero-extend readdata to 32 bits; writes to read-only addresses SHALL have no effect.
REQ-016 SHALL update DATA on the rising edge ending the write cycle and reflect the change on out_port from that edge (1-cycle latency).
REQ-017 SHALL drive out_port = DATA XOR active_mask.
REQ-018 SHALL handle a PULSE write with nonzero mask M and PLEN≠0 as follows:
- active_mask <= active_mask | M.
- counter <= PLEN.
REQ-019 SHALL decrement the counter each cycle while it is nonzero; on the 1→0 transition active_mask SHALL clear to 0, so masked bits are inverted for exactly PLEN cycles.
REQ-020 SHALL handle a PULSE write on the same cycle the counter reaches 0 with reload priority (mask = old|M, counter = PLEN).
REQ-021 SHALL ignore a PULSE write with M=0 or PLEN=0.
REQ-022 SHALL let DATA, SET and CLR writes during an active pulse change DATA only; the inversion continues on the new DATA.
REQ-023 SHALL NOT alter an in-flight pulse on a PLEN write; the new value applies to the next PULSE write.
REQ-024 SHALL implement a two-state pulse FSM: IDLE (counter=0, mask=0) → ACTIVE on a valid PULSE write; ACTIVE → IDLE at counter 1→0.

Reset
REQ-025 SHALL set, on reset_n=0 (asynchronous):
- DATA=RESET_VALUE.
- PLEN=DEFAULT_PLEN.
- counter=0.
- active_mask=0.
- out_port=RESET_VALUE.
REQ-026 SHALL, on reset assertion mid-pulse, abort the pulse immediately and return to IDLE.

Configuration
REQ-027 SHALL compile the pulse feature in when macro PIO_OUT_MULTI_PULSE_EN is defined, with REQ-018..REQ-024 in effect.
REQ-028 SHALL, when PIO_OUT_MULTI_PULSE_EN is undefined, omit the counter, mask and FSM; addresses 3–5 SHALL read 0 and ignore writes, and out_port SHALL equal DATA.

Verification
REQ-029 SHALL cover, with WIDTH=8: reset → out_port=0x00, PLEN reads 16, PCNT reads 0.
REQ-030 SHALL cover: write DATA=0xA5, then SET=0x0A, then CLR=0x81 → out_port goes 0xA5, 0xAF, 0x2E, each one cycle after its write.
REQ-031 SHALL cover: DATA=0x00, PLEN=3, PULSE=0x01 → out_port=0x01 for exactly 3 cycles, then 0x00; PCNT reads 3,2,1,0.
REQ-032 SHALL cover: PLEN=5, PULSE=0x01, then PULSE=0x02 two cycles later → out_port=0x03 for 5 cycles after the second write, then 0x00.
REQ-033 SHALL cover: PLEN=0, PULSE=0xFF → no change on out_port, PCNT=0; and reset_n low mid-pulse → out_port=RESET_VALUE asynchronously.
REQ-034 SHALL cover, with the macro undefined: PULSE=0xFF → out_port unchanged; reads of addresses 3–5 return 0.
